div_repsub: RTL and testbench
=============================

DIV_REPSUB -- requirements
Module: div_repsub

Interface
REQ-001: Parameter WIDTH, default 16, operand, quotient and remainder width in bits.
REQ-002: clk  input  1  single clock, all state updates on rising edge.
REQ-003: rst  input  1  asynchronous, active-high reset.
REQ-004: start  input  1  request level, sampled in S_IDLE and S_DONE.
REQ-005: data_in  input  WIDTH  serial operand bus: dividend one cycle, divisor the next.
REQ-006: quotient  output  WIDTH  registered quotient, valid while done=1.
REQ-007: remainder  output  WIDTH  registered remainder, valid while done=1.
REQ-008: busy  output  1  high in S_LDA, S_LDB and S_SUB.
REQ-009: done  output  1  high only in S_DONE.

Function
REQ-010: The FSM SHALL have states S_IDLE, S_LDA, S_LDB, S_SUB and S_DONE, encoded as one-hot or binary.
- S_IDLE: when start=1, go to S_LDA; otherwise stay.
- S_LDA: capture data_in into dividend register A; go to S_LDB.
- S_LDB: capture data_in into divisor register B; clear Q.
  - If data_in=0, go to S_DONE.
  - Otherwise, go to S_SUB.
- S_SUB: if A>=B, then A<=A-B and Q<=Q+1; otherwise go to S_DONE. Each state is one clock.
- S_DONE: hold outputs. If start=0, go to S_IDLE; if start=1, stay in S_DONE. No retrigger without start first going low.
REQ-011: Comparison and subtraction SHALL be unsigned, at WIDTH bits. Q cannot overflow because Q<=dividend.
REQ-012: Latency, from the edge that samples start to the edge that enters S_DONE, SHALL be floor(N/D)+4 cycles for D!=0, and 3 cycles for D=0.
REQ-013: quotient=Q and remainder=A, driven directly from registers with no combinational path from inputs.
REQ-014: Divide by zero SHALL give quotient all-ones, remainder=dividend, and done asserted normally.
REQ-015: data_in SHALL be ignored outside S_LDA and S_LDB. start SHALL be ignored in S_LDA, S_LDB and S_SUB.

Reset
REQ-016: rst=1 SHALL immediately force S_IDLE and set A=B=Q=0, giving quotient=0, remainder=0, busy=0 and done=0.
REQ-017: Reset asserted mid-operation in any state SHALL abort with no partial result. The first start sampled after rst falls SHALL begin a fresh load.

Configuration
REQ-018: With macro DIV_REPSUB_DBZ_EN defined, an extra output port dbz (1 bit) SHALL exist. It is a registered flag, set on entry to S_DONE via the divide-by-zero path, cleared on leaving S_DONE and on reset.
REQ-019: Without DIV_REPSUB_DBZ_EN, the dbz port and its register SHALL be absent. Divide-by-zero results per REQ-014 are unchanged.

Structure
REQ-020: A shared package div_repsub_pkg SHALL hold the state typedef (S_IDLE through S_DONE) and the WIDTH default constant.
REQ-021: Split into one sub-module div_repsub_ctrl (the FSM, driving lda, ldb, clrq, sub and done) and a datapath in the top (A, B and Q registers, comparator, subtractor). Same controller/datapath split as the existing multiplier.

Verification
REQ-022: start=1, dividend 17, then divisor 5 -> quotient=3, remainder=2; done rises 7 edges after the start-sampling edge; busy low in S_DONE.
REQ-023: 4/5 -> quotient=0, remainder=4 after 4 edges. 10/10 -> quotient=1, remainder=0 after 5 edges.
REQ-024: 20/0 -> S_DONE after 3 edges, quotient=16'hFFFF, remainder=20; dbz=1 only when DIV_REPSUB_DBZ_EN is defined.
REQ-025: 16'hFFFF/1 -> quotient=16'hFFFF, remainder=0 after 65539 edges, with no wrap of Q.
REQ-026: Reset scenarios:
- rst pulsed asynchronously (between edges) during S_SUB of 17/5 -> all outputs 0 at once.
- A following 9/4 run -> quotient=2, remainder=1.
REQ-027: Hold start=1 through S_DONE -> done stays high and no new load occurs. Then drop start -> S_IDLE on the next edge.

Source files
------------

// File: rtl/div_repsub_pkg.sv
// Shared definitions for the repeated-subtraction divider.
//   state_t       : controller state encoding (S_IDLE .. S_DONE)
//   WIDTH_DEFAULT : default operand / quotient / remainder width
// Optional feature macro: DIV_REPSUB_DBZ_EN (adds the dbz flag output).
package div_repsub_pkg;

    localparam int WIDTH_DEFAULT = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LDA,
        S_LDB,
        S_SUB,
        S_DONE
    } state_t;

endpackage

// File: rtl/div_repsub_ctrl.sv
// Controller FSM for the repeated-subtraction divider.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : request level, honoured only in S_IDLE and S_DONE
//   din_zero  : data_in is zero (meaningful in S_LDB for divide-by-zero)
//   a_ge_b    : datapath comparison A >= B
//   lda, ldb  : load strobes for dividend / divisor registers
//   clrq      : initialise the quotient register (in S_LDB)
//   sub       : perform one A <= A - B, Q <= Q + 1 step
//   busy      : registered, high in S_LDA, S_LDB and S_SUB
//   done      : registered, high only in S_DONE
//   dbz       : (DIV_REPSUB_DBZ_EN only) registered divide-by-zero flag
module div_repsub_ctrl
    import div_repsub_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic din_zero,
    input  logic a_ge_b,
    output logic lda,
    output logic ldb,
    output logic clrq,
    output logic sub,
    output logic busy,
    output logic done
`ifdef DIV_REPSUB_DBZ_EN
    ,
    output logic dbz
`endif
);

    state_t state_q, state_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
`ifdef DIV_REPSUB_DBZ_EN
    logic   dbz_q, dbz_d;
`endif

    // Next-state logic. busy/done are derived from the next state so that
    // they are registered alongside the state and line up with it exactly.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_LDA;
            S_LDA:   state_d = S_LDB;
            S_LDB:   state_d = din_zero ? S_DONE : S_SUB;
            S_SUB:   if (!a_ge_b) state_d = S_DONE;
            S_DONE:  if (!start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_LDA) || (state_d == S_LDB) || (state_d == S_SUB);
        done_d = (state_d == S_DONE);
`ifdef DIV_REPSUB_DBZ_EN
        // Set only when S_DONE is entered straight from S_LDB with a zero
        // divisor; held while parked in S_DONE, dropped on leaving it.
        dbz_d = 1'b0;
        if (state_q == S_LDB && din_zero) begin
            dbz_d = 1'b1;
        end else if (state_q == S_DONE && state_d == S_DONE) begin
            dbz_d = dbz_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIV_REPSUB_DBZ_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DIV_REPSUB_DBZ_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    // Datapath strobes are decoded from the current state so they act in
    // the same cycle the state is occupied.
    assign lda  = (state_q == S_LDA);
    assign ldb  = (state_q == S_LDB);
    assign clrq = (state_q == S_LDB);
    assign sub  = (state_q == S_SUB) && a_ge_b;

    assign busy = busy_q;
    assign done = done_q;
`ifdef DIV_REPSUB_DBZ_EN
    assign dbz  = dbz_q;
`endif

endmodule

// File: rtl/div_repsub.sv
// Unsigned divider by repeated subtraction: dividend and divisor arrive
// serially on data_in, then B is subtracted from A until A < B.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start               : request level
//   data_in [WIDTH]     : dividend one cycle, divisor the next
//   quotient [WIDTH]    : Q register, valid while done=1
//   remainder [WIDTH]   : A register, valid while done=1
//   busy, done          : status from the controller
//   dbz                 : divide-by-zero flag, present only when
//                         DIV_REPSUB_DBZ_EN is defined
// Divide by zero yields quotient all-ones and remainder = dividend.
module div_repsub
    import div_repsub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done
`ifdef DIV_REPSUB_DBZ_EN
    ,
    output logic             dbz
`endif
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             lda, ldb, clrq, sub;
    logic             din_zero;
    logic             a_ge_b;

    assign din_zero = (data_in == '0);
    assign a_ge_b   = (a_q >= b_q);

    div_repsub_ctrl u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .din_zero (din_zero),
        .a_ge_b   (a_ge_b),
        .lda      (lda),
        .ldb      (ldb),
        .clrq     (clrq),
        .sub      (sub),
        .busy     (busy),
        .done     (done)
`ifdef DIV_REPSUB_DBZ_EN
        ,
        .dbz      (dbz)
`endif
    );

    // Datapath next values. Loading a zero divisor presets Q to all-ones,
    // which is the divide-by-zero quotient; A then already holds the
    // dividend, which is the required remainder. Q never wraps because it
    // can count at most up to the dividend.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        q_d = q_q;
        if (lda) begin
            a_d = data_in;
        end
        if (ldb) begin
            b_d = data_in;
        end
        if (clrq) begin
            q_d = din_zero ? {WIDTH{1'b1}} : '0;
        end
        if (sub) begin
            a_d = a_q - b_q;
            q_d = q_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            q_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            q_q <= q_d;
        end
    end

    assign quotient  = q_q;
    assign remainder = a_q;

endmodule

// File: tb/tb_div_repsub.sv
// Self-checking bench for div_repsub: directed divisions with hand-computed
// results, compared both against literals and against an arithmetic model.
// Define DIV_REPSUB_DBZ_EN to also exercise the dbz flag.
module tb_div_repsub;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] data_in;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
`ifdef DIV_REPSUB_DBZ_EN
    logic         dbz;
`endif

    int total = 0;
    int bad   = 0;

    // Expected results of the division currently in flight.
    logic         exp_valid = 1'b0;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic [W-1:0] exp_d;

    div_repsub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .data_in   (data_in),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done)
`ifdef DIV_REPSUB_DBZ_EN
        ,
        .dbz       (dbz)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic model of the divider results and latency.
    function automatic logic [W-1:0] model_q(input logic [W-1:0] n, input logic [W-1:0] d);
        if (d == '0) return {W{1'b1}};
        return n / d;
    endfunction

    function automatic logic [W-1:0] model_r(input logic [W-1:0] n, input logic [W-1:0] d);
        if (d == '0) return n;
        return n % d;
    endfunction

    function automatic int model_lat(input logic [W-1:0] n, input logic [W-1:0] d);
        if (d == '0) return 3;
        return int'(n / d) + 4;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Whenever a result is being presented, it must match the model and
    // the divider must not report busy.
    always @(negedge clk) begin
        if (exp_valid && done === 1'b1) begin
            checkOutput("model_quotient", 32'(quotient), 32'(exp_q));
            checkOutput("model_remainder", 32'(remainder), 32'(exp_r));
            checkOutput("busy_in_done", 32'(busy), 32'd0);
`ifdef DIV_REPSUB_DBZ_EN
            checkOutput("dbz_in_done", 32'(dbz), 32'(exp_d == '0));
`endif
        end
    end

    // Runs one division starting at a falling edge. Edges are counted with
    // the start-sampling edge as edge 1. With hold=1, start stays high
    // through S_DONE for a few cycles before being dropped.
    task automatic applyStimulus(input logic [W-1:0] n, input logic [W-1:0] d,
                                 input bit hold, input logic [W-1:0] lit_q,
                                 input logic [W-1:0] lit_r, input int lit_lat);
        int edges;
        int limit;
        exp_q     = model_q(n, d);
        exp_r     = model_r(n, d);
        exp_d     = d;
        exp_valid = 1'b1;
        limit     = model_lat(n, d) + 8;
        start     = 1'b1;
        data_in   = 16'hA5A5;
        @(posedge clk);
        edges = 1;
        #1;
        if (!hold) start = 1'b0;
        data_in = n;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        @(posedge clk);
        edges++;
        #1 data_in = d;
        @(posedge clk);
        edges++;
        #1 data_in = 16'h5A5A;
        @(negedge clk);
        while (done !== 1'b1 && edges < limit) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            data_in = 16'($urandom);
        end
        checkOutput("done_seen", 32'(done), 32'd1);
        checkOutput("latency_model", 32'(edges), 32'(model_lat(n, d)));
        checkOutput("latency_literal", 32'(edges), 32'(lit_lat));
        checkOutput("quotient_literal", 32'(quotient), 32'(lit_q));
        checkOutput("remainder_literal", 32'(remainder), 32'(lit_r));
        if (hold) begin
            repeat (3) begin
                data_in = 16'($urandom);
                @(posedge clk);
                @(negedge clk);
                checkOutput("done_held", 32'(done), 32'd1);
                checkOutput("busy_held", 32'(busy), 32'd0);
            end
            start = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        exp_valid = 1'b0;
        checkOutput("done_cleared", 32'(done), 32'd0);
        checkOutput("busy_idle", 32'(busy), 32'd0);
`ifdef DIV_REPSUB_DBZ_EN
        checkOutput("dbz_cleared", 32'(dbz), 32'd0);
`endif
    endtask

    // Starts 17/5, then pulses reset between edges while in S_SUB.
    task automatic abortBySubReset();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        data_in = 16'd17;
        @(posedge clk);
        #1 data_in = 16'd5;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("abort_quotient", 32'(quotient), 32'd0);
        checkOutput("abort_remainder", 32'(remainder), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        data_in = '0;
        #1 rst  = 1'b1;
        #2;
        checkOutput("reset_quotient", 32'(quotient), 32'd0);
        checkOutput("reset_remainder", 32'(remainder), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
`ifdef DIV_REPSUB_DBZ_EN
        checkOutput("reset_dbz", 32'(dbz), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(16'd17,    16'd5,  1'b0, 16'd3,    16'd2,  7);
        applyStimulus(16'd4,     16'd5,  1'b0, 16'd0,    16'd4,  4);
        applyStimulus(16'd10,    16'd10, 1'b0, 16'd1,    16'd0,  5);
        applyStimulus(16'd20,    16'd0,  1'b0, 16'hFFFF, 16'd20, 3);
        applyStimulus(16'd0,     16'd7,  1'b0, 16'd0,    16'd0,  4);
        applyStimulus(16'd100,   16'd7,  1'b0, 16'd14,   16'd2,  18);
        applyStimulus(16'd6,     16'd3,  1'b1, 16'd2,    16'd0,  6);
        applyStimulus(16'd5,     16'd0,  1'b1, 16'hFFFF, 16'd5,  3);

        abortBySubReset();
        applyStimulus(16'd9,     16'd4,  1'b0, 16'd2,    16'd1,  6);

        applyStimulus(16'hFFFF,  16'd1,  1'b0, 16'hFFFF, 16'd0,  65539);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
